// File: rtl/cp0_exception_unit_pkg.sv
// Shared definitions for the CP0 exception unit.
// Holds CP0 register addresses, ExcCode values, Status/Cause bit positions
// and the BadVAddr source select used between the priority encoder and the top.
package cp0_exception_unit_pkg;

  // CP0 register numbers
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // Status bit positions
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_BEV = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IPHW_LO = 10;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  // Which value (if any) is captured into BadVAddr
  typedef enum logic [1:0] {
    BADADDR_NONE = 2'd0,
    BADADDR_PC   = 2'd1,
    BADADDR_MEM  = 2'd2
  } badaddr_sel_e;

endpackage

// File: rtl/cp0_exception_unit_prio.sv
// cp0_exc_prio: combinational exception priority encoder.
// Inputs : inst_valid, int_pending and the per-instruction exception sources.
// Outputs: exc_valid (non-eret exception taken), exc_code (winning ExcCode),
//          is_eret (eret taken, nothing else pending), badaddr_sel.
module cp0_exc_prio
  import cp0_exception_unit_pkg::*;
(
  input  logic         inst_valid,
  input  logic         int_pending,
  input  logic         adel_if,
  input  logic         ri,
  input  logic         ov,
  input  logic         syscall,
  input  logic         brk,
  input  logic         adel_mem,
  input  logic         ades,
  input  logic         eret,
  output logic         exc_valid,
  output logic [4:0]   exc_code,
  output logic         is_eret,
  output badaddr_sel_e badaddr_sel
);

  always_comb begin
    exc_valid   = 1'b0;
    exc_code    = EXC_INT;
    is_eret     = 1'b0;
    badaddr_sel = BADADDR_NONE;
    if (inst_valid) begin
      if (int_pending) begin
        exc_valid = 1'b1;
        exc_code  = EXC_INT;
      end else if (adel_if) begin
        exc_valid   = 1'b1;
        exc_code    = EXC_ADEL;
        badaddr_sel = BADADDR_PC;
      end else if (ri) begin
        exc_valid = 1'b1;
        exc_code  = EXC_RI;
      end else if (ov) begin
        exc_valid = 1'b1;
        exc_code  = EXC_OV;
      end else if (syscall) begin
        exc_valid = 1'b1;
        exc_code  = EXC_SYS;
      end else if (brk) begin
        exc_valid = 1'b1;
        exc_code  = EXC_BP;
      end else if (adel_mem) begin
        exc_valid   = 1'b1;
        exc_code    = EXC_ADEL;
        badaddr_sel = BADADDR_MEM;
      end else if (ades) begin
        exc_valid   = 1'b1;
        exc_code    = EXC_ADES;
        badaddr_sel = BADADDR_MEM;
      end else if (eret) begin
        is_eret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: CP0 register file and precise-exception controller (MEM stage).
// Ports: clk/rst (sync, active-high); inst_valid, pc, in_delayslot and exception
// sources; mem_addr (faulting data address); ext_int[5:0]; mtc0 write port
// (we/waddr/wdata); mfc0 read (raddr -> rdata); flush/new_pc redirect;
// status_o/cause_o/epc_o mirrors.
// Optional feature macro CP0_TIMER_EN builds Count/Compare and the TI timer interrupt.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] pc,
  input  logic        in_delayslot,
  input  logic        adel_if,
  input  logic        ri,
  input  logic        syscall,
  input  logic        brk,
  input  logic        ov,
  input  logic        adel_mem,
  input  logic        ades,
  input  logic        eret,
  input  logic [31:0] mem_addr,
  input  logic [5:0]  ext_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;

  logic [31:0] count_val, compare_val;
  logic        ti_val;

  logic         int_pending, exc_valid, is_eret, wr_en;
  logic [4:0]   exc_code;
  badaddr_sel_e badaddr_sel;

  always_comb begin
    status_o = '0;
    status_o[STATUS_BEV] = 1'b1;
    status_o[STATUS_IM_LO +: 8] = im_q;
    status_o[STATUS_EXL] = exl_q;
    status_o[STATUS_IE]  = ie_q;
  end

  always_comb begin
    cause_o = '0;
    cause_o[CAUSE_BD] = bd_q;
    cause_o[CAUSE_TI] = ti_val;
    cause_o[CAUSE_IPHW_LO +: 6] = ip_hw_q;
    cause_o[CAUSE_IP_LO +: 2]   = ip_sw_q;
    cause_o[CAUSE_EXC_LO +: 5]  = exccode_q;
  end

  assign epc_o = epc_q;

  assign int_pending = ie_q & ~exl_q & (|(cause_o[CAUSE_IP_LO +: 8] & im_q));

  cp0_exc_prio u_prio (
    .inst_valid  (inst_valid),
    .int_pending (int_pending),
    .adel_if     (adel_if),
    .ri          (ri),
    .ov          (ov),
    .syscall     (syscall),
    .brk         (brk),
    .adel_mem    (adel_mem),
    .ades        (ades),
    .eret        (eret),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .is_eret     (is_eret),
    .badaddr_sel (badaddr_sel)
  );

  // A faulting instruction must not commit its mtc0 side effect.
  assign wr_en = we & ~exc_valid;

  assign flush  = exc_valid | is_eret;
  assign new_pc = exc_valid ? EXC_VECTOR : (is_eret ? epc_q : '0);

  always_comb begin
    case (raddr)
      ADDR_BADVADDR: rdata = badvaddr_q;
      ADDR_COUNT:    rdata = count_val;
      ADDR_COMPARE:  rdata = compare_val;
      ADDR_STATUS:   rdata = status_o;
      ADDR_CAUSE:    rdata = cause_o;
      ADDR_EPC:      rdata = epc_q;
      ADDR_PRID:     rdata = PRID_VAL;
      default:       rdata = '0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_hw_d    = {ext_int[5] | ti_val, ext_int[4:0]};

    if (wr_en) begin
      case (waddr)
        ADDR_STATUS: begin
          im_d  = wdata[STATUS_IM_LO +: 8];
          exl_d = wdata[STATUS_EXL];
          ie_d  = wdata[STATUS_IE];
        end
        ADDR_CAUSE: ip_sw_d = wdata[CAUSE_IP_LO +: 2];
        ADDR_EPC:   epc_d   = wdata;
        default: ;
      endcase
    end

    if (exc_valid) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = in_delayslot ? (pc - 32'd4) : pc;
        bd_d  = in_delayslot;
      end
      case (badaddr_sel)
        BADADDR_PC:  badvaddr_d = pc;
        BADADDR_MEM: badvaddr_d = mem_addr;
        default: ;
      endcase
    end else if (is_eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_d_unused_guard: begin end
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tick_q, tick_d, ti_q, ti_d;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = tick_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    // TI is sticky until software rewrites Compare.
    ti_d      = ti_q | (count_q == compare_q);
    if (wr_en && (waddr == ADDR_COUNT)) begin
      count_d = wdata;
      tick_d  = 1'b0;
    end
    if (wr_en && (waddr == ADDR_COMPARE)) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count_val   = count_q;
  assign compare_val = compare_q;
  assign ti_val      = ti_q;
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign ti_val      = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit.
module tb_cp0_exception_unit;

  logic        clk, rst, inst_valid, in_delayslot;
  logic [31:0] pc, mem_addr, wdata, rdata, new_pc, status_o, cause_o, epc_o;
  logic        adel_if, ri, syscall, brk, ov, adel_mem, ades, eret, we, flush;
  logic [5:0]  ext_int;
  logic [4:0]  waddr, raddr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] v;

  cp0_exception_unit #(
    .EXC_VECTOR (32'hBFC0_0380),
    .PRID_VAL   (32'h0000_4220)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .in_delayslot (in_delayslot),
    .adel_if      (adel_if),
    .ri           (ri),
    .syscall      (syscall),
    .brk          (brk),
    .ov           (ov),
    .adel_mem     (adel_mem),
    .ades         (ades),
    .eret         (eret),
    .mem_addr     (mem_addr),
    .ext_int      (ext_int),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .flush        (flush),
    .new_pc       (new_pc),
    .status_o     (status_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic idle();
    inst_valid = 1'b0; in_delayslot = 1'b0; pc = '0; mem_addr = '0;
    adel_if = 1'b0; ri = 1'b0; syscall = 1'b0; brk = 1'b0; ov = 1'b0;
    adel_mem = 1'b0; ades = 1'b0; eret = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  // eret with an expected return target, leaves EXL cleared
  task automatic do_eret(input string tag, input logic [31:0] exp_pc);
    inst_valid = 1'b1; eret = 1'b1;
    #1;
    check_eq({tag, "_flush"}, {31'd0, flush}, 32'd1);
    check_eq({tag, "_newpc"}, new_pc, exp_pc);
    step();
    idle();
  endtask

  initial begin
    idle();
    ext_int = '0;
    raddr = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // reset state (before any post-reset edge)
    #1;
    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_newpc", new_pc, 32'd0);
    rd(5'd0, v);  check_eq("rst_r0", v, 32'd0);
    rd(5'd12, v); check_eq("rst_status", v, 32'h0040_0000);
    rd(5'd13, v); check_eq("rst_cause", v, 32'd0);
    rd(5'd14, v); check_eq("rst_epc", v, 32'd0);
    rd(5'd15, v); check_eq("rst_prid", v, 32'h0000_4220);
    rd(5'd8, v);  check_eq("rst_badv", v, 32'd0);

    // park Compare far away so TI stays quiet in timer builds
    mtc0(5'd11, 32'hFFFF_FFFF);

    // syscall, not in a delay slot
    inst_valid = 1'b1; syscall = 1'b1; pc = 32'hBFC0_0100;
    #1;
    check_eq("sys_flush", {31'd0, flush}, 32'd1);
    check_eq("sys_newpc", new_pc, 32'hBFC0_0380);
    step(); idle();
    rd(5'd14, v); check_eq("sys_epc", v, 32'hBFC0_0100);
    rd(5'd13, v); check_eq("sys_cause", v, 32'h0000_0020);
    rd(5'd12, v); check_eq("sys_status", v, 32'h0040_0002);

    // eret returns to software-written EPC
    mtc0(5'd14, 32'h0000_2000);
    rd(5'd14, v); check_eq("epc_wr", v, 32'h0000_2000);
    do_eret("eret1", 32'h0000_2000);
    rd(5'd12, v); check_eq("eret1_status", v, 32'h0040_0000);

    // ri beats ades; delay-slot EPC adjust
    inst_valid = 1'b1; ri = 1'b1; ades = 1'b1; in_delayslot = 1'b1;
    pc = 32'h0000_1004; mem_addr = 32'hDEAD_0000;
    #1;
    check_eq("ri_newpc", new_pc, 32'hBFC0_0380);
    step(); idle();
    rd(5'd14, v); check_eq("ri_epc", v, 32'h0000_1000);
    rd(5'd13, v); check_eq("ri_cause", v, 32'h8000_0028);
    rd(5'd8, v);  check_eq("ri_badv", v, 32'd0);
    do_eret("eret2", 32'h0000_1000);

    // adel_mem suppresses a same-cycle mtc0 to EPC
    inst_valid = 1'b1; adel_mem = 1'b1; pc = 32'h0000_3000; mem_addr = 32'h0000_0123;
    we = 1'b1; waddr = 5'd14; wdata = 32'hFFFF_0000;
    step(); idle();
    rd(5'd14, v); check_eq("adelm_epc", v, 32'h0000_3000);
    rd(5'd8, v);  check_eq("adelm_badv", v, 32'h0000_0123);
    rd(5'd13, v); check_eq("adelm_cause", v, 32'h0000_0010);

    // nested (EXL=1): ov beats syscall; EPC and BD untouched
    inst_valid = 1'b1; ov = 1'b1; syscall = 1'b1; brk = 1'b1; in_delayslot = 1'b1;
    pc = 32'h0000_5000;
    step(); idle();
    rd(5'd14, v); check_eq("nest_epc", v, 32'h0000_3000);
    rd(5'd13, v); check_eq("nest_cause", v, 32'h0000_0030);
    do_eret("eret3", 32'h0000_3000);

    // adel_if beats ri; BadVAddr takes pc
    inst_valid = 1'b1; adel_if = 1'b1; ri = 1'b1; pc = 32'h0000_0ABD; mem_addr = 32'h0000_0FFF;
    step(); idle();
    rd(5'd8, v);  check_eq("adelif_badv", v, 32'h0000_0ABD);
    rd(5'd13, v); check_eq("adelif_cause", v, 32'h0000_0010);
    do_eret("eret4", 32'h0000_0ABD);

    // read-only / unlisted writes are ignored
    mtc0(5'd8, 32'h1234_5678);
    mtc0(5'd3, 32'h1234_5678);
    rd(5'd8, v); check_eq("badv_ro", v, 32'h0000_0ABD);
    rd(5'd3, v); check_eq("unlisted_rd", v, 32'd0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, v); check_eq("status_mask", v, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); check_eq("cause_mask", v, 32'h0000_0310);

    // software interrupt wins over syscall
    mtc0(5'd12, 32'h0040_0101);
    #1;
    check_eq("int_noinst", {31'd0, flush}, 32'd0);
    inst_valid = 1'b1; syscall = 1'b1; pc = 32'h0000_6000;
    #1;
    check_eq("int_flush", {31'd0, flush}, 32'd1);
    step(); idle();
    rd(5'd13, v); check_eq("int_cause", v, 32'h0000_0300);
    rd(5'd14, v); check_eq("int_epc", v, 32'h0000_6000);
    rd(5'd12, v); check_eq("int_status", v, 32'h0040_0103);
    mtc0(5'd12, 32'h0000_0000);
    mtc0(5'd13, 32'h0000_0000);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0040_8001);
    inst_valid = 1'b1; pc = 32'h0000_7000;
    for (int i = 0; i < 40; i++) begin
      if (flush) break;
      step();
    end
    check_eq("tmr_flush", {31'd0, flush}, 32'd1);
    step(); idle();
    rd(5'd13, v); check_eq("tmr_exccode", {27'd0, v[6:2]}, 32'd0);
    check_eq("tmr_ti_set", {31'd0, v[30]}, 32'd1);
    mtc0(5'd11, 32'd100);
    rd(5'd13, v); check_eq("tmr_ti_clr", {31'd0, v[30]}, 32'd0);
    rd(5'd11, v); check_eq("tmr_cmp", v, 32'd100);
`else
    mtc0(5'd9, 32'd77);
    rd(5'd9, v);  check_eq("cnt_off", v, 32'd0);
    rd(5'd11, v); check_eq("cmp_off", v, 32'd0);
`endif

    // reset during an exception overrides the update
    mtc0(5'd14, 32'h0000_4444);
    inst_valid = 1'b1; syscall = 1'b1; pc = 32'h0000_8000; rst = 1'b1;
    step(); idle(); rst = 1'b0;
    rd(5'd12, v); check_eq("rstx_status", v, 32'h0040_0000);
    rd(5'd14, v); check_eq("rstx_epc", v, 32'd0);
    rd(5'd13, v); check_eq("rstx_cause", v, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
